// File: rtl/userrom_spi_arbiter.sv
// Arbiter sharing the user SPI bus (USERROM flash + FRAM) between the bubble
// page loader and the FRAM save writer. It grants one master at a time,
// registers the owner's SPI drive onto the pins, inserts a deselect guard gap
// between owners and forcibly releases a master that holds the bus too long.
module userrom_spi_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic       MCLK,
  input  logic       nRESET,
  input  logic       LDR_REQ,
  output logic       LDR_GNT,
  input  logic       LDR_nCS_FLASH,
  input  logic       LDR_nCS_FRAM,
  input  logic       LDR_CLK,
  input  logic       LDR_MOSI,
  input  logic       SAV_REQ,
  output logic       SAV_GNT,
  input  logic       SAV_nCS_FLASH,
  input  logic       SAV_nCS_FRAM,
  input  logic       SAV_CLK,
  input  logic       SAV_MOSI,
  input  logic       SAV_INHIBIT,
  output logic       USERROM_FLASH_nCS,
  output logic       USERROM_FRAM_nCS,
  output logic       USERROM_CLK,
  output logic       USERROM_MOSI,
  output logic [1:0] OWNER,
  output logic       TIMEOUT_ERR
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_LAST   = GW'(GUARD_CYCLES - 1);
  // {flash nCS, fram nCS, CLK, MOSI} with both chips deselected
  localparam logic [3:0] PINS_IDLE = 4'b1100;

  // Encodings double as the OWNER output value
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LDR   = 2'b01,
    ST_SAV   = 2'b10,
    ST_GUARD = 2'b11
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nx;
  logic [GW-1:0] grd_cnt, grd_cnt_nx;
  logic          last_sav, last_sav_nx;
  logic          ldr_lock, sav_lock;
  logic          set_ldr_lock, set_sav_lock;
  logic          ldr_elig, sav_elig;
  logic [3:0]    pins_nx;

  // Next-state arbitration, grant timeout and guard-gap sequencing
  always_comb begin
    state_nx     = state;
    tmo_cnt_nx   = tmo_cnt;
    grd_cnt_nx   = grd_cnt;
    last_sav_nx  = last_sav;
    set_ldr_lock = 1'b0;
    set_sav_lock = 1'b0;
    ldr_elig     = LDR_REQ & ~ldr_lock;
    sav_elig     = SAV_REQ & ~SAV_INHIBIT & ~sav_lock;
    unique case (state)
      ST_IDLE: begin
        tmo_cnt_nx = '0;
        // Round-robin: on a tie the master that did not own the bus last wins
        if (ldr_elig && (!sav_elig || last_sav)) begin
          state_nx = ST_LDR;
        end else if (sav_elig) begin
          state_nx = ST_SAV;
        end
      end
      ST_LDR: begin
        if (!LDR_REQ || tmo_cnt == TIMEOUT_LAST) begin
          state_nx     = ST_GUARD;
          grd_cnt_nx   = '0;
          last_sav_nx  = 1'b0;
          set_ldr_lock = LDR_REQ;
        end else begin
          tmo_cnt_nx = tmo_cnt + TW'(1);
        end
      end
      ST_SAV: begin
        if (!SAV_REQ || tmo_cnt == TIMEOUT_LAST) begin
          state_nx     = ST_GUARD;
          grd_cnt_nx   = '0;
          last_sav_nx  = 1'b1;
          set_sav_lock = SAV_REQ;
        end else begin
          tmo_cnt_nx = tmo_cnt + TW'(1);
        end
      end
      ST_GUARD: begin
        if (grd_cnt == GUARD_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          grd_cnt_nx = grd_cnt + GW'(1);
        end
      end
    endcase
  end

  // Pin values for the coming cycle: the owner's drive, else deselected
  always_comb begin
    pins_nx = PINS_IDLE;
    if (state_nx == ST_LDR) begin
      pins_nx = {LDR_nCS_FLASH, LDR_nCS_FRAM, LDR_CLK, LDR_MOSI};
    end else if (state_nx == ST_SAV) begin
      pins_nx = {SAV_nCS_FLASH, SAV_nCS_FRAM, SAV_CLK, SAV_MOSI};
    end
  end

  // State, counters and rotation pointer
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      grd_cnt  <= '0;
      last_sav <= 1'b1;
    end else begin
      state    <= state_nx;
      tmo_cnt  <= tmo_cnt_nx;
      grd_cnt  <= grd_cnt_nx;
      last_sav <= last_sav_nx;
    end
  end

  // Lockout after a forced release, held until the master drops its request
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      ldr_lock <= 1'b0;
      sav_lock <= 1'b0;
    end else begin
      if (set_ldr_lock)  ldr_lock <= 1'b1;
      else if (!LDR_REQ) ldr_lock <= 1'b0;
      if (set_sav_lock)  sav_lock <= 1'b1;
      else if (!SAV_REQ) sav_lock <= 1'b0;
    end
  end

  // Registered outputs, all derived from the next state on the same edge
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      LDR_GNT     <= 1'b0;
      SAV_GNT     <= 1'b0;
      OWNER       <= 2'b00;
      TIMEOUT_ERR <= 1'b0;
      {USERROM_FLASH_nCS, USERROM_FRAM_nCS, USERROM_CLK, USERROM_MOSI} <= PINS_IDLE;
    end else begin
      LDR_GNT     <= (state_nx == ST_LDR);
      SAV_GNT     <= (state_nx == ST_SAV);
      OWNER       <= state_nx;
      TIMEOUT_ERR <= set_ldr_lock | set_sav_lock;
      {USERROM_FLASH_nCS, USERROM_FRAM_nCS, USERROM_CLK, USERROM_MOSI} <= pins_nx;
    end
  end

endmodule

// File: tb/tb_userrom_spi_arbiter.sv
// Directed self-checking bench for userrom_spi_arbiter (GUARD 4, TIMEOUT 16).
module tb_userrom_spi_arbiter;

  logic       MCLK = 1'b0;
  logic       nRESET;
  logic       ldr_req, ldr_ncs_flash, ldr_ncs_fram, ldr_clk, ldr_mosi;
  logic       sav_req, sav_ncs_flash, sav_ncs_fram, sav_clk, sav_mosi;
  logic       sav_inhibit;
  logic       LDR_GNT, SAV_GNT, TIMEOUT_ERR;
  logic       flash_ncs, fram_ncs, spi_clk, spi_mosi;
  logic [1:0] OWNER;
  logic [3:0] pins;

  localparam logic [3:0] IDLE = 4'b1100;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  userrom_spi_arbiter #(
    .GUARD_CYCLES  (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .MCLK             (MCLK),
    .nRESET           (nRESET),
    .LDR_REQ          (ldr_req),
    .LDR_GNT          (LDR_GNT),
    .LDR_nCS_FLASH    (ldr_ncs_flash),
    .LDR_nCS_FRAM     (ldr_ncs_fram),
    .LDR_CLK          (ldr_clk),
    .LDR_MOSI         (ldr_mosi),
    .SAV_REQ          (sav_req),
    .SAV_GNT          (SAV_GNT),
    .SAV_nCS_FLASH    (sav_ncs_flash),
    .SAV_nCS_FRAM     (sav_ncs_fram),
    .SAV_CLK          (sav_clk),
    .SAV_MOSI         (sav_mosi),
    .SAV_INHIBIT      (sav_inhibit),
    .USERROM_FLASH_nCS(flash_ncs),
    .USERROM_FRAM_nCS (fram_ncs),
    .USERROM_CLK      (spi_clk),
    .USERROM_MOSI     (spi_mosi),
    .OWNER            (OWNER),
    .TIMEOUT_ERR      (TIMEOUT_ERR)
  );

  assign pins = {flash_ncs, fram_ncs, spi_clk, spi_mosi};

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic set_ldr(input logic [3:0] v);
    {ldr_ncs_flash, ldr_ncs_fram, ldr_clk, ldr_mosi} = v;
  endtask

  task automatic set_sav(input logic [3:0] v);
    {sav_ncs_flash, sav_ncs_fram, sav_clk, sav_mosi} = v;
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    tick();
    tick();
    nRESET = 1'b1;
  endtask

  // Continuous invariants: one-hot grant, OWNER agrees with GNT, idle pins when unowned
  always @(negedge MCLK) begin
    logic [1:0] exp_gnt;
    exp_gnt = (OWNER == 2'b01) ? 2'b10 : (OWNER == 2'b10) ? 2'b01 : 2'b00;
    check("gnt_onehot", {31'b0, LDR_GNT & SAV_GNT}, 0);
    check("owner_gnt", {LDR_GNT, SAV_GNT}, exp_gnt);
    if (!LDR_GNT && !SAV_GNT) check("idle_pins", pins, IDLE);
  end

  initial begin
    nRESET = 1'b0;
    ldr_req = 1'b0; sav_req = 1'b0; sav_inhibit = 1'b0;
    set_ldr(IDLE); set_sav(IDLE);

    // 1. Reset with toggling inputs, release mid-toggle, async reset during save grant
    for (int i = 0; i < 6; i++) begin
      {ldr_req, sav_req, sav_inhibit} = 3'($urandom);
      set_ldr(4'($urandom)); set_sav(4'($urandom));
      tick();
      check("rst_pins", pins, IDLE);
      check("rst_gnt", {LDR_GNT, SAV_GNT}, 0);
      check("rst_owner", OWNER, 0);
      check("rst_err", TIMEOUT_ERR, 0);
    end
    ldr_req = 1'b0; sav_req = 1'b0;
    set_ldr(4'($urandom)); set_sav(4'($urandom));
    #2 nRESET = 1'b1;
    tick();
    check("rel_owner", OWNER, 0);
    check("rel_pins", pins, IDLE);
    sav_req = 1'b1; sav_inhibit = 1'b0; set_sav(4'b0000); set_ldr(IDLE);
    tick();
    check("sav_grant", SAV_GNT, 1);
    check("sav_pins", pins, 4'b0000);
    #2 nRESET = 1'b0;
    #1;
    check("async_pins", pins, IDLE);
    check("async_gnt", SAV_GNT, 0);
    check("async_owner", OWNER, 0);
    sav_req = 1'b0; set_sav(IDLE);
    #2 nRESET = 1'b1;
    tick();

    // 2. Loader grant latency and one-cycle pin delay
    ldr_req = 1'b1;
    tick();
    check("t2_gnt", LDR_GNT, 1);
    check("t2_owner", OWNER, 2'b01);
    tick();
    ldr_ncs_flash = 1'b0;
    tick();
    tick();
    check("t2_flash_ncs", flash_ncs, 0);
    begin
      logic [3:0] clk_pat, mosi_pat;
      logic       prev_clk;
      clk_pat  = 4'b1010;  // LSB first: 0,1,0,1
      mosi_pat = 4'b0110;
      prev_clk = ldr_clk;
      for (int i = 0; i < 4; i++) begin
        ldr_clk  = clk_pat[i];
        ldr_mosi = mosi_pat[i];
        #1 check("t2_clk_late", spi_clk, prev_clk);
        tick();
        check("t2_clk", spi_clk, clk_pat[i]);
        check("t2_mosi", spi_mosi, mosi_pat[i]);
        prev_clk = clk_pat[i];
      end
    end
    ldr_req = 1'b0; set_ldr(IDLE);
    tick();
    check("t2_rel_gnt", LDR_GNT, 0);
    check("t2_rel_owner", OWNER, 2'b11);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t2_guard_owner", OWNER, 2'b11);
    end
    tick();
    check("t2_idle_owner", OWNER, 2'b00);

    // 3. Simultaneous requests, guard gap and rotation
    do_reset();
    ldr_req = 1'b1; sav_req = 1'b1; sav_inhibit = 1'b0;
    tick();
    check("t3_first_ldr", LDR_GNT, 1);
    check("t3_first_sav", SAV_GNT, 0);
    tick(); tick();
    ldr_req = 1'b0;
    tick();
    check("t3_ldr_fall", LDR_GNT, 0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) ldr_req = 1'b1;
      tick();
      check("t3_guard_sav", SAV_GNT, 0);
      check("t3_guard_ldr", LDR_GNT, 0);
    end
    tick();
    check("t3_sav_n5", SAV_GNT, 1);
    check("t3_sav_owner", OWNER, 2'b10);
    sav_req = 1'b0;
    tick();
    check("t3_sav_fall", SAV_GNT, 0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 3) sav_req = 1'b1;
      tick();
      check("t3_guard2_ldr", LDR_GNT, 0);
    end
    tick();
    check("t3_rot_ldr", LDR_GNT, 1);
    check("t3_rot_sav", SAV_GNT, 0);
    ldr_req = 1'b0; sav_req = 1'b0;
    repeat (5) tick();

    // 4. SAV_INHIBIT blocks save grants, loader unaffected, no preemption
    sav_inhibit = 1'b1; sav_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic exp_l;
      exp_l = ((i >= 10 && i < 16) || (i >= 40 && i < 46));
      ldr_req = exp_l;
      tick();
      check("t4_ldr_gnt", LDR_GNT, exp_l);
      check("t4_sav_blocked", SAV_GNT, 0);
    end
    sav_inhibit = 1'b0;
    tick();
    check("t4_sav_m1", SAV_GNT, 1);
    sav_inhibit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_no_preempt", SAV_GNT, 1);
    end
    sav_req = 1'b0; sav_inhibit = 1'b0;
    tick();
    check("t4_sav_rel", SAV_GNT, 0);
    repeat (4) tick();

    // 5. Forced release after 16 granted cycles, lockout until REQ drops
    set_ldr(4'b0000);
    ldr_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("t5_gnt", LDR_GNT, (i < 16));
      check("t5_err", TIMEOUT_ERR, (i == 16));
      check("t5_owner", OWNER, (i < 16) ? 2'b01 : (i < 20) ? 2'b11 : 2'b00);
      check("t5_pins", pins, (i < 16) ? 4'b0000 : IDLE);
    end
    ldr_req = 1'b0;
    tick();
    check("t5_drop_gnt", LDR_GNT, 0);
    ldr_req = 1'b1;
    tick();
    check("t5_regrant", LDR_GNT, 1);
    check("t5_regrant_err", TIMEOUT_ERR, 0);
    ldr_req = 1'b0; set_ldr(IDLE);
    repeat (5) tick();

    // 6. Isolation: pins follow only the loader while random save activity runs
    for (int w = 0; w < 17; w++) begin
      ldr_req = 1'b1; sav_req = 1'b0; set_ldr(IDLE);
      tick();
      check("t6_grant", LDR_GNT, 1);
      for (int i = 0; i < 12; i++) begin
        logic [3:0] exp_pins;
        {sav_req, sav_inhibit} = 2'($urandom);
        set_sav(4'($urandom));
        exp_pins = 4'($urandom);
        set_ldr(exp_pins);
        tick();
        check("t6_pins", pins, exp_pins);
        check("t6_sav_gnt", SAV_GNT, 0);
      end
      ldr_req = 1'b0; sav_req = 1'b0; set_ldr(IDLE);
      repeat (5) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
